// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store back end of the EX stage.
//  Takes the byte address and store data from operand prep and runs one access at a
//  time over a req/ack data-memory bus. Stores are lane-replicated with byte strobes.
//  Loads are shifted down to the addressed lane and sign- or zero-extended. The core
//  is stalled until the access completes.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//  defined   - misaligned half/word accesses skip the bus and finish with ls_misalign=1
//  undefined - low address bits are truncated to natural alignment, ls_misalign stays 0
//
// Ports:
//  clk, rst_n         clock, asynchronous active-low reset
//  ls_valid           EX holds a load/store (operands stable until ls_done)
//  ls_we              1 = store, 0 = load
//  ls_size            00 byte, 01 half, 10/11 word
//  ls_unsigned        zero-extend byte/half loads
//  addr_mem           byte address
//  data_store         store data
//  ls_stall           combinational: ls_valid & ~ls_done
//  ls_done            one-cycle completion pulse
//  load_data          aligned, extended load result
//  ls_err             bus timeout on the last access
//  ls_misalign        misaligned access trapped on the last access
//  mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   registered bus request
//  mem_ack/mem_rdata  bus response
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] addr_mem,
    input  logic [31:0] data_store,
    output logic        ls_stall,
    output logic        ls_done,
    output logic [31:0] load_data,
    output logic        ls_err,
    output logic        ls_misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       off_q, off_d;

    logic             mem_req_d, mem_we_d, ls_done_d, ls_err_d, ls_misalign_d;
    logic [31:0]      mem_addr_d, mem_wdata_d, load_data_d;
    logic [3:0]       mem_wstrb_d;

    logic [31:0]      st_wdata_c;
    logic [3:0]       st_wstrb_c;
    logic [4:0]       ld_shift_c;
    logic [31:0]      ld_shifted_c;
    logic [31:0]      ld_data_c;
    logic             misalign_c;

    assign ls_stall = ls_valid & ~ls_done;
    assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef LSU_MISALIGN_TRAP_EN
    // Half needs even address, word needs 4-byte alignment.
    assign misalign_c = ((ls_size == 2'b01) && addr_mem[0]) ||
                        (ls_size[1] && (addr_mem[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane replication and strobes from the live request.
    always_comb begin
        st_wdata_c = data_store;
        st_wstrb_c = 4'b1111;
        case (ls_size)
            2'b00: begin
                st_wdata_c = {4{data_store[7:0]}};
                st_wstrb_c = 4'b0001 << addr_mem[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{data_store[15:0]}};
                st_wstrb_c = 4'b0011 << {addr_mem[1], 1'b0};
            end
            default: begin
                st_wdata_c = data_store;
                st_wstrb_c = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and extension from the captured access attributes.
    always_comb begin
        ld_shift_c = 5'd0;
        case (size_q)
            2'b00:   ld_shift_c = {off_q, 3'b000};
            2'b01:   ld_shift_c = {off_q[1], 4'b0000};
            default: ld_shift_c = 5'd0;
        endcase
        ld_shifted_c = mem_rdata >> ld_shift_c;
        case (size_q)
            2'b00:   ld_data_c = {{24{~uns_q & ld_shifted_c[7]}},  ld_shifted_c[7:0]};
            2'b01:   ld_data_c = {{16{~uns_q & ld_shifted_c[15]}}, ld_shifted_c[15:0]};
            default: ld_data_c = ld_shifted_c;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        size_d        = size_q;
        uns_d         = uns_q;
        off_d         = off_q;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_wstrb_d   = mem_wstrb;
        load_data_d   = load_data;
        ls_err_d      = ls_err;
        ls_misalign_d = ls_misalign;
        ls_done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ls_valid) begin
                    size_d        = ls_size;
                    uns_d         = ls_unsigned;
                    off_d         = addr_mem[1:0];
                    ls_err_d      = 1'b0;
                    ls_misalign_d = misalign_c;
                    if (misalign_c) begin
                        load_data_d = '0;
                        ls_done_d   = 1'b1;
                        state_d     = DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = ls_we;
                        mem_addr_d  = {addr_mem[31:2], 2'b00};
                        mem_wdata_d = st_wdata_c;
                        mem_wstrb_d = ls_we ? st_wstrb_c : 4'b0000;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                // An ack in the timeout cycle takes priority over the abort.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    ls_done_d = 1'b1;
                    state_d   = DONE;
                    if (!mem_we) begin
                        load_data_d = ld_data_c;
                    end
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    mem_req_d   = 1'b0;
                    ls_err_d    = 1'b1;
                    load_data_d = '0;
                    ls_done_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= 4'b0000;
            load_data   <= '0;
            ls_err      <= 1'b0;
            ls_misalign <= 1'b0;
            ls_done     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_wstrb   <= mem_wstrb_d;
            load_data   <= load_data_d;
            ls_err      <= ls_err_d;
            ls_misalign <= ls_misalign_d;
            ls_done     <= ls_done_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench for lsu_mem_ctrl with a short bus timeout.
module tb_lsu_mem_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_we, ls_unsigned, mem_ack;
    logic [1:0]  ls_size;
    logic [31:0] addr_mem, data_store, mem_rdata;
    logic        ls_stall, ls_done, ls_err, ls_misalign, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    // Observations from the last run_access call.
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_wstrb;
    logic        obs_we, obs_err, obs_mis, obs_req_done, obs_stall_done, obs_stall_first;
    int          obs_req_cyc, obs_lat;
    logic        got_done;

    lsu_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ls_valid   (ls_valid),
        .ls_we      (ls_we),
        .ls_size    (ls_size),
        .ls_unsigned(ls_unsigned),
        .addr_mem   (addr_mem),
        .data_store (data_store),
        .ls_stall   (ls_stall),
        .ls_done    (ls_done),
        .load_data  (load_data),
        .ls_err     (ls_err),
        .ls_misalign(ls_misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access; ack is raised in REQ cycle ack_wait+1 (large ack_wait = never).
    task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input int ack_wait);
        @(negedge clk);
        ls_we = we; ls_size = size; ls_unsigned = uns;
        addr_mem = addr; data_store = data; mem_rdata = rdata;
        mem_ack = 1'b0; ls_valid = 1'b1;
        obs_addr = 32'hFFFF_FFFF; obs_wdata = 32'hFFFF_FFFF; obs_wstrb = 4'hF; obs_we = 1'bx;
        obs_req_cyc = 0; obs_lat = 0; got_done = 1'b0; obs_stall_first = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            obs_lat++;
            if (i == 0) obs_stall_first = ls_stall;
            if (ls_done) begin
                got_done       = 1'b1;
                obs_ld         = load_data;
                obs_err        = ls_err;
                obs_mis        = ls_misalign;
                obs_req_done   = mem_req;
                obs_stall_done = ls_stall;
                break;
            end
            if (mem_req) begin
                if (obs_req_cyc == 0) begin
                    obs_addr  = mem_addr;
                    obs_wdata = mem_wdata;
                    obs_wstrb = mem_wstrb;
                    obs_we    = mem_we;
                end
                obs_req_cyc++;
                mem_ack = (obs_req_cyc > ack_wait);
            end
        end
        mem_ack  = 1'b0;
        ls_valid = 1'b0;
        check("done_seen", 32'(got_done), 32'd1);
        @(posedge clk); #1;
        check("done_pulse", 32'(ls_done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ls_valid = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
        addr_mem = '0; data_store = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(mem_req),     32'd0);
        check("rst_done",  32'(ls_done),     32'd0);
        check("rst_ld",    load_data,        32'd0);
        check("rst_err",   32'(ls_err),      32'd0);
        check("rst_mis",   32'(ls_misalign), 32'd0);
        check("rst_strb",  32'(mem_wstrb),   32'd0);
        check("rst_addr",  mem_addr,         32'd0);
        check("rst_stall", 32'(ls_stall),    32'd0);
        rst_n = 1'b1;

        // SW, ack in first REQ cycle
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
        check("sw_addr",   obs_addr,  32'h0000_0100);
        check("sw_wstrb",  32'(obs_wstrb), 32'hF);
        check("sw_wdata",  obs_wdata, 32'hDEAD_BEEF);
        check("sw_we",     32'(obs_we), 32'd1);
        check("sw_lat",    obs_lat,   2);
        check("sw_stall0", 32'(obs_stall_first), 32'd1);
        check("sw_stallD", 32'(obs_stall_done), 32'd0);
        check("sw_reqD",   32'(obs_req_done), 32'd0);

        // LB / LBU at lane 3
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        check("lb_addr",  obs_addr, 32'h0000_0100);
        check("lb_wstrb", 32'(obs_wstrb), 32'h0);
        check("lb_data",  obs_ld,   32'hFFFF_FF80);
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        check("lbu_data", obs_ld,   32'h0000_0080);

        // SH upper half; load_data must not change on a store
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
        check("sh_wstrb", 32'(obs_wstrb), 32'hC);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh_ldkeep", load_data, 32'h0000_0080);
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_0000, 0);
        check("lh_data",  obs_ld, 32'hFFFF_8001);
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_0000, 0);
        check("lhu_data", obs_ld, 32'h0000_8001);

        // SB lane 1, ack late
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h1234_565A, 32'h0, 2);
        check("sb_wstrb", 32'(obs_wstrb), 32'h2);
        check("sb_wdata", obs_wdata, 32'h5A5A_5A5A);
        check("sb_lat",   obs_lat, 4);

        // Timeout: no ack
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h1111_1111, 1000);
        check("to_reqcyc", obs_req_cyc, int'(TO));
        check("to_err",    32'(obs_err), 32'd1);
        check("to_ld",     obs_ld, 32'd0);
        check("to_reqD",   32'(obs_req_done), 32'd0);
        check("to_errhold", 32'(ls_err), 32'd1);

        // Ack in the timeout cycle wins
        run_access(1'b0, 2'b10, 1'b1, 32'h0000_0404, 32'h0, 32'h8765_4321, int'(TO) - 1);
        check("tie_err",   32'(obs_err), 32'd0);
        check("tie_ld",    obs_ld, 32'h8765_4321);
        check("tie_reqcyc", obs_req_cyc, int'(TO));

        // Size 11 treated as word
        run_access(1'b0, 2'b11, 1'b0, 32'h0000_0108, 32'h0, 32'h1234_5678, 0);
        check("w11_ld", obs_ld, 32'h1234_5678);

        // Reset in REQ of a store
        @(negedge clk);
        ls_we = 1'b1; ls_size = 2'b10; addr_mem = 32'h0000_0500; data_store = 32'h0BAD_F00D;
        ls_valid = 1'b1;
        @(posedge clk); #1;
        check("rr_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_reqlow", 32'(mem_req), 32'd0);
        check("rr_stall",  32'(ls_stall), 32'd1);
        ls_valid = 1'b0;
        #1;
        check("rr_stall0", 32'(ls_stall), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_0500, 32'h0BAD_F00D, 32'h0, 0);
        check("rr_lat",   obs_lat, 2);
        check("rr_wdata", obs_wdata, 32'h0BAD_F00D);

        // LW misaligned
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'h0, 32'hCAFE_F00D, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_reqcyc", obs_req_cyc, 0);
        check("mis_flag",   32'(obs_mis), 32'd1);
        check("mis_ld",     obs_ld, 32'd0);
        check("mis_lat",    obs_lat, 1);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0);
        check("mis_clear",  32'(obs_mis), 32'd0);
        check("mis_ld2",    obs_ld, 32'hCAFE_F00D);
`else
        check("mis_addr", obs_addr, 32'h0000_0300);
        check("mis_ld",   obs_ld, 32'hCAFE_F00D);
        check("mis_flag", 32'(obs_mis), 32'd0);
        check("mis_err",  32'(obs_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
